// File: rtl/seq_alu_pkg.sv
// Shared ALU select codes, FSM state encoding and select-decode helper for seq_alu.
package seq_alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        SEQ_ALU_IDLE  = 2'd0,
        SEQ_ALU_SHIFT = 2'd1,
        SEQ_ALU_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_sel(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/seq_alu_comb.sv
// Single-cycle ALU operations. With SEQ_ALU_BARREL_EN defined, shifts are barrel-shifted here;
// otherwise shift selects pass op_a through (the shamt==0 result) and the top iterates.
module seq_alu_comb
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result
);

`ifdef SEQ_ALU_BARREL_EN
    localparam int SHAMT_W = $clog2(WIDTH);
    logic [SHAMT_W-1:0] shamt;
    assign shamt = op_b[SHAMT_W-1:0];
`endif

    always_comb begin
        result = '0;
        case (alu_sel)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_SLT:  result = WIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU: result = WIDTH'(op_a < op_b);
            ALU_XOR:  result = op_a ^ op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_AND:  result = op_a & op_b;
`ifdef SEQ_ALU_BARREL_EN
            ALU_SLL:  result = op_a << shamt;
            ALU_SRL:  result = op_a >> shamt;
            ALU_SRA:  result = WIDTH'($signed(op_a) >>> shamt);
`else
            ALU_SLL, ALU_SRL, ALU_SRA: result = op_a;
`endif
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready on both sides; shifts iterate one bit per cycle
// unless SEQ_ALU_BARREL_EN is defined, in which case every operation completes in one cycle.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic [WIDTH-1:0] comb_result;

`ifndef SEQ_ALU_BARREL_EN
    localparam int SHAMT_W = $clog2(WIDTH);
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W-1:0] count;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   shifted;
    logic [3:0]         sel_q;
    logic               start_shift;

    assign shamt       = op_b[SHAMT_W-1:0];
    assign start_shift = is_shift_sel(alu_sel) && (shamt != '0);

    always_comb begin
        shifted = work;
        case (sel_q)
            ALU_SLL: shifted = {work[WIDTH-2:0], 1'b0};
            ALU_SRL: shifted = {1'b0, work[WIDTH-1:1]};
            ALU_SRA: shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            default: shifted = work;
        endcase
    end
`endif

    assign accept = in_valid & in_ready;

    seq_alu_comb #(.WIDTH(WIDTH)) u_comb (
        .alu_sel (alu_sel),
        .op_a    (op_a),
        .op_b    (op_b),
        .result  (comb_result)
    );

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            SEQ_ALU_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifndef SEQ_ALU_BARREL_EN
                    next_state = start_shift ? SEQ_ALU_SHIFT : SEQ_ALU_DONE;
`else
                    next_state = SEQ_ALU_DONE;
`endif
                end
            end
`ifndef SEQ_ALU_BARREL_EN
            SEQ_ALU_SHIFT: begin
                if (count == SHAMT_W'(1)) next_state = SEQ_ALU_DONE;
            end
`endif
            SEQ_ALU_DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = SEQ_ALU_IDLE;
            end
            default: next_state = SEQ_ALU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SEQ_ALU_IDLE;
            result <= '0;
            zero   <= 1'b0;
`ifndef SEQ_ALU_BARREL_EN
            work   <= '0;
            count  <= '0;
            sel_q  <= ALU_ADD;
`endif
        end else begin
            state <= next_state;
            case (state)
                SEQ_ALU_IDLE: begin
                    if (accept) begin
`ifndef SEQ_ALU_BARREL_EN
                        if (start_shift) begin
                            work  <= op_a;
                            count <= shamt;
                            sel_q <= alu_sel;
                        end else begin
                            result <= comb_result;
                            zero   <= (comb_result == '0);
                        end
`else
                        result <= comb_result;
                        zero   <= (comb_result == '0);
`endif
                    end
                end
`ifndef SEQ_ALU_BARREL_EN
                // The final shift step writes the output registers directly so DONE sees it next cycle.
                SEQ_ALU_SHIFT: begin
                    work  <= shifted;
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        result <= shifted;
                        zero   <= (shifted == '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases with literal expectations, then randomized traffic.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_sel = '0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (s)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
            ALU_SLTU: return (a < b) ? 1 : 0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return W'($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return '0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] s, input logic [W-1:0] b);
`ifdef SEQ_ALU_BARREL_EN
        return 1;
`else
        if ((s == ALU_SLL || s == ALU_SRL || s == ALU_SRA) && b[4:0] != 0) return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    // Reference: idle/busy/holding described by a countdown of cycles until the result appears.
    bit           m_idle = 1'b1;
    int           m_wait = 0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_pend = '0;
    logic         m_zero = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_idle = 1'b1; m_wait = 0; m_res = '0; m_zero = 1'b0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_pend = ref_op(alu_sel, op_a, op_b);
                m_wait = ref_lat(alu_sel, op_b) - 1;
                m_idle = 1'b0;
                if (m_wait == 0) begin m_res = m_pend; m_zero = (m_pend == 0); end
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin m_res = m_pend; m_zero = (m_pend == 0); end
        end else if (out_ready) begin
            m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("in_ready", W'(in_ready), W'(m_idle));
            check("out_valid", W'(out_valid), W'(!m_idle && m_wait == 0));
            if (!m_idle && m_wait == 0) begin
                check("result", result, m_res);
                check("zero", W'(zero), W'(m_zero));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) check("wait_ready timeout", 0, 1);
    endtask

    task automatic run_op(input string name, input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_zero, input int exp_lat);
        int lat;
        wait_ready();
        in_valid = 1'b1; alu_sel = s; op_a = a; op_b = b;
        @(negedge clk);
        in_valid = 1'b0; op_a = ~a; op_b = ~b; alu_sel = ALU_AND;
        lat = 1;
        while (!out_valid && lat < 100) begin
            check({name, " in_ready busy"}, W'(in_ready), 0);
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, W'(lat), W'(exp_lat));
        check({name, " result"}, result, exp_res);
        check({name, " zero"}, W'(zero), W'(exp_zero));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " in_ready after"}, W'(in_ready), 1);
    endtask

    initial begin
        int lat_sra4, lat_sll31;
`ifdef SEQ_ALU_BARREL_EN
        lat_sra4 = 1; lat_sll31 = 1;
`else
        lat_sra4 = 5; lat_sll31 = 32;
`endif
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b0;
        check("reset in_ready", W'(in_ready), 1);
        check("reset out_valid", W'(out_valid), 0);
        check("reset result", result, 0);
        check("reset zero", W'(zero), 0);
        checking = 1'b1;

        run_op("add 5+7", ALU_ADD, 5, 7, 12, 1'b0, 1);
        run_op("sub 3-5", ALU_SUB, 3, 5, 32'hFFFF_FFFE, 1'b0, 1);
        run_op("sub 9-9", ALU_SUB, 9, 9, 0, 1'b1, 1);
        run_op("sra 4", ALU_SRA, 32'h8000_0000, 4, 32'hF800_0000, 1'b0, lat_sra4);
        run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 1, 1, 1'b0, 1);
        run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 1, 0, 1'b1, 1);
        run_op("sll 0", ALU_SLL, 1, 0, 1, 1'b0, 1);
        run_op("sll 31", ALU_SLL, 1, 31, 32'h8000_0000, 1'b0, lat_sll31);
        run_op("srl 1", ALU_SRL, 32'h8000_0001, 1, 32'h4000_0000, 1'b0, ref_lat(ALU_SRL, 1));
        run_op("bad sel", 4'b1111, 5, 5, 0, 1'b1, 1);

        // Consumer stall: result held three cycles, then handshake.
        wait_ready();
        in_valid = 1'b1; alu_sel = ALU_ADD; op_a = 5; op_b = 7;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hold out_valid", W'(out_valid), 1);
            check("hold result", result, 12);
            check("hold in_ready", W'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("hold 4th out_valid", W'(out_valid), 1);
        @(negedge clk);
        out_ready = 1'b0;
        check("hold release in_ready", W'(in_ready), 1);
        check("hold release out_valid", W'(out_valid), 0);

        // Reset in the middle of a long shift.
        wait_ready();
        in_valid = 1'b1; alu_sel = ALU_SRL; op_a = 32'hFFFF_FFFF; op_b = 20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
`ifndef SEQ_ALU_BARREL_EN
        check("srl20 busy out_valid", W'(out_valid), 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst in_ready", W'(in_ready), 1);
        check("mid rst out_valid", W'(out_valid), 0);
        check("mid rst result", result, 0);
        check("mid rst zero", W'(zero), 0);

        for (int c = 0; c < 6000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            alu_sel   = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: op_a = 32'h8000_0000;
                1: op_a = '0;
                default: op_a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: op_b = op_a;
                1: op_b = W'($urandom_range(0, 3));
                default: op_b = $urandom;
            endcase
            out_ready = ($urandom_range(0, 4) < 3);
            rst       = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
